icache_req_arbiter: RTL and testbench

Shares the single ICache request port between the fetch stage and the next-line instruction prefetcher, ahead of `icache_interface`. It keeps at most one request in flight, tags it with its owner, and routes the response (or TLB fetch exception) back to that owner. Fetch always has priority and can pre-empt an in-flight prefetch by killing it. A saturating PMU counter records dropped and pre-empted prefetches.

---
 rtl/drac_pkg.sv | 15 +
 rtl/icache_req_arbiter_sat_counter.sv | 31 +++
 rtl/icache_req_arbiter.sv | 126 ++++++++++++
 tb/tb_icache_req_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/drac_pkg.sv
// Shared front-end types: address/line widths plus the ICache request arbiter's state encoding.
package drac_pkg;

    typedef logic [39:0]  addr_t;
    typedef logic [127:0] icache_line_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FETCH = 2'd1,
        WAIT_PF    = 2'd2
    } arb_state_t;

    localparam int PF_CNT_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/icache_req_arbiter_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/icache_req_arbiter.sv
// Shares the ICache request port between fetch and the next-line prefetcher,
// one access in flight, response routed back to whoever owns it.
module icache_req_arbiter
    import drac_pkg::*;
#(
    parameter int PF_CNT_WIDTH = PF_CNT_WIDTH_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    fetch_req_valid_i,
    input  addr_t                   fetch_req_vaddr_i,
    input  logic                    fetch_kill_i,
    output logic                    fetch_req_ready_o,
    input  logic                    pf_req_valid_i,
    input  addr_t                   pf_req_vaddr_i,
    output logic                    pf_req_ready_o,
    output logic                    icache_req_valid_o,
    output addr_t                   icache_req_vaddr_o,
    output logic                    icache_req_kill_o,
    input  logic                    icache_req_ready_i,
    input  logic                    icache_resp_valid_i,
    input  icache_line_t            icache_resp_datablock_i,
    input  logic                    tlb_resp_xcp_if_i,
    output logic                    fetch_resp_valid_o,
    output icache_line_t            fetch_resp_data_o,
    output logic                    fetch_resp_xcpt_o,
    output logic                    pf_resp_valid_o,
    output addr_t                   pf_resp_vaddr_o,
    output icache_line_t            pf_resp_data_o,
    output logic [PF_CNT_WIDTH-1:0] pf_drop_cnt_o
);

    arb_state_t state_q, state_d;
    addr_t      addr_q, addr_d;
    logic       drop_inc;

    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        drop_inc           = 1'b0;
        fetch_req_ready_o  = 1'b0;
        pf_req_ready_o     = 1'b0;
        icache_req_valid_o = 1'b0;
        icache_req_vaddr_o = '0;
        icache_req_kill_o  = 1'b0;
        fetch_resp_valid_o = 1'b0;
        fetch_resp_data_o  = '0;
        fetch_resp_xcpt_o  = 1'b0;
        pf_resp_valid_o    = 1'b0;
        pf_resp_vaddr_o    = '0;
        pf_resp_data_o     = '0;

        case (state_q)
            IDLE: begin
                // A prefetch losing to fetch is simply retried, so it is not a drop.
                if (fetch_req_valid_i && icache_req_ready_i) begin
                    fetch_req_ready_o  = 1'b1;
                    icache_req_valid_o = 1'b1;
                    icache_req_vaddr_o = fetch_req_vaddr_i;
                    addr_d             = fetch_req_vaddr_i;
                    state_d            = WAIT_FETCH;
                end else if (pf_req_valid_i && icache_req_ready_i) begin
                    pf_req_ready_o     = 1'b1;
                    icache_req_valid_o = 1'b1;
                    icache_req_vaddr_o = pf_req_vaddr_i;
                    addr_d             = pf_req_vaddr_i;
                    state_d            = WAIT_PF;
                end
            end

            WAIT_FETCH: begin
                // A redirect beats any same-cycle response: the line is stale.
                if (fetch_kill_i) begin
                    icache_req_kill_o = 1'b1;
                    state_d           = IDLE;
                end else if (icache_resp_valid_i || tlb_resp_xcp_if_i) begin
                    fetch_resp_valid_o = 1'b1;
                    fetch_resp_data_o  = icache_resp_datablock_i;
                    fetch_resp_xcpt_o  = tlb_resp_xcp_if_i;
                    state_d            = IDLE;
                end
            end

            WAIT_PF: begin
                if (tlb_resp_xcp_if_i) begin
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end else if (icache_resp_valid_i) begin
                    pf_resp_valid_o = 1'b1;
                    pf_resp_vaddr_o = addr_q;
                    pf_resp_data_o  = icache_resp_datablock_i;
                    state_d         = IDLE;
                end else if (fetch_req_valid_i) begin
                    // Pre-empt: fetch is granted from IDLE on the following cycle.
                    icache_req_kill_o = 1'b1;
                    drop_inc          = 1'b1;
                    state_d           = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    sat_counter #(
        .WIDTH (PF_CNT_WIDTH)
    ) u_pf_drop_cnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .inc_i  (drop_inc),
        .cnt_o  (pf_drop_cnt_o)
    );

endmodule

// File: tb/tb_icache_req_arbiter.sv
// Directed bench for icache_req_arbiter: per-cycle vector table plus
// hand sequences for counter saturation and mid-access reset.
module tb_icache_req_arbiter;
    import drac_pkg::*;

    localparam int W = 2;

    logic         clk;
    logic         rstn;
    logic         fetch_req_valid;
    addr_t        fetch_req_vaddr;
    logic         fetch_kill;
    logic         fetch_req_ready;
    logic         pf_req_valid;
    addr_t        pf_req_vaddr;
    logic         pf_req_ready;
    logic         icache_req_valid;
    addr_t        icache_req_vaddr;
    logic         icache_req_kill;
    logic         icache_req_ready;
    logic         icache_resp_valid;
    icache_line_t icache_resp_data;
    logic         tlb_xcpt;
    logic         fetch_resp_valid;
    icache_line_t fetch_resp_data;
    logic         fetch_resp_xcpt;
    logic         pf_resp_valid;
    addr_t        pf_resp_vaddr;
    icache_line_t pf_resp_data;
    logic [W-1:0] pf_drop_cnt;

    int checks = 0;
    int errors = 0;

    icache_req_arbiter #(.PF_CNT_WIDTH(W)) dut (
        .clk_i                   (clk),
        .rstn_i                  (rstn),
        .fetch_req_valid_i       (fetch_req_valid),
        .fetch_req_vaddr_i       (fetch_req_vaddr),
        .fetch_kill_i            (fetch_kill),
        .fetch_req_ready_o       (fetch_req_ready),
        .pf_req_valid_i          (pf_req_valid),
        .pf_req_vaddr_i          (pf_req_vaddr),
        .pf_req_ready_o          (pf_req_ready),
        .icache_req_valid_o      (icache_req_valid),
        .icache_req_vaddr_o      (icache_req_vaddr),
        .icache_req_kill_o       (icache_req_kill),
        .icache_req_ready_i      (icache_req_ready),
        .icache_resp_valid_i     (icache_resp_valid),
        .icache_resp_datablock_i (icache_resp_data),
        .tlb_resp_xcp_if_i       (tlb_xcpt),
        .fetch_resp_valid_o      (fetch_resp_valid),
        .fetch_resp_data_o       (fetch_resp_data),
        .fetch_resp_xcpt_o       (fetch_resp_xcpt),
        .pf_resp_valid_o         (pf_resp_valid),
        .pf_resp_vaddr_o         (pf_resp_vaddr),
        .pf_resp_data_o          (pf_resp_data),
        .pf_drop_cnt_o           (pf_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         fv;
        addr_t        fa;
        logic         fk;
        logic         pv;
        addr_t        pa;
        logic         rdy;
        logic         rv;
        logic         tlb;
        logic         e_frdy;
        logic         e_pfrdy;
        logic         e_iv;
        addr_t        e_ia;
        logic         e_kill;
        logic         e_frv;
        logic         e_fx;
        logic         e_prv;
        addr_t        e_pa;
        logic [W-1:0] e_cnt;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic zero_inputs();
        fetch_req_valid   = 1'b0;
        fetch_req_vaddr   = '0;
        fetch_kill        = 1'b0;
        pf_req_valid      = 1'b0;
        pf_req_vaddr      = '0;
        icache_req_ready  = 1'b0;
        icache_resp_valid = 1'b0;
        icache_resp_data  = '0;
        tlb_xcpt          = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " fetch_ready"}, 128'(fetch_req_ready), 128'd0);
        chk({tag, " pf_ready"},    128'(pf_req_ready), 128'd0);
        chk({tag, " req_valid"},   128'(icache_req_valid), 128'd0);
        chk({tag, " req_vaddr"},   128'(icache_req_vaddr), 128'd0);
        chk({tag, " kill"},        128'(icache_req_kill), 128'd0);
        chk({tag, " fetch_rv"},    128'(fetch_resp_valid), 128'd0);
        chk({tag, " fetch_data"},  fetch_resp_data, 128'd0);
        chk({tag, " fetch_xcpt"},  128'(fetch_resp_xcpt), 128'd0);
        chk({tag, " pf_rv"},       128'(pf_resp_valid), 128'd0);
        chk({tag, " pf_vaddr"},    128'(pf_resp_vaddr), 128'd0);
        chk({tag, " pf_data"},     pf_resp_data, 128'd0);
        chk({tag, " cnt"},         128'(pf_drop_cnt), 128'd0);
    endtask

    icache_line_t line_base;
    icache_line_t line;
    icache_line_t exp_fd;
    icache_line_t exp_pd;

    initial begin
        line_base = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_0001;

        //            fv fa            fk pv pa     rdy rv tlb  frdy pfrdy iv ia            kill frv fx prv pa     cnt
        // fetch only
        vecs[0]  = '{1, 40'h8000_0010, 0, 0, 40'h0,   1, 0, 0,   1, 0,  1, 40'h8000_0010, 0, 0, 0, 0, 40'h0,   2'd0};
        vecs[1]  = '{0, 40'h0,         0, 0, 40'h0,   0, 0, 0,   0, 0,  0, 40'h0,         0, 0, 0, 0, 40'h0,   2'd0};
        vecs[2]  = '{0, 40'h0,         0, 0, 40'h0,   0, 1, 0,   0, 0,  0, 40'h0,         0, 1, 0, 0, 40'h0,   2'd0};
        vecs[3]  = '{0, 40'h0,         0, 0, 40'h0,   1, 0, 0,   0, 0,  0, 40'h0,         0, 0, 0, 0, 40'h0,   2'd0};
        // simultaneous fetch + prefetch
        vecs[4]  = '{1, 40'h100,       0, 1, 40'h140, 1, 0, 0,   1, 0,  1, 40'h100,       0, 0, 0, 0, 40'h0,   2'd0};
        vecs[5]  = '{0, 40'h0,         0, 1, 40'h140, 1, 1, 0,   0, 0,  0, 40'h0,         0, 1, 0, 0, 40'h0,   2'd0};
        vecs[6]  = '{0, 40'h0,         0, 1, 40'h140, 1, 0, 0,   0, 1,  1, 40'h140,       0, 0, 0, 0, 40'h0,   2'd0};
        vecs[7]  = '{0, 40'h0,         0, 0, 40'h0,   1, 1, 0,   0, 0,  0, 40'h0,         0, 0, 0, 1, 40'h140, 2'd0};
        // pre-emption of prefetch 0x200 by fetch 0x300
        vecs[8]  = '{0, 40'h0,         0, 1, 40'h200, 1, 0, 0,   0, 1,  1, 40'h200,       0, 0, 0, 0, 40'h0,   2'd0};
        vecs[9]  = '{1, 40'h300,       0, 0, 40'h0,   1, 0, 0,   0, 0,  0, 40'h0,         1, 0, 0, 0, 40'h0,   2'd0};
        vecs[10] = '{1, 40'h300,       0, 0, 40'h0,   1, 0, 0,   1, 0,  1, 40'h300,       0, 0, 0, 0, 40'h0,   2'd1};
        vecs[11] = '{0, 40'h0,         0, 0, 40'h0,   1, 1, 0,   0, 0,  0, 40'h0,         0, 1, 0, 0, 40'h0,   2'd1};
        // kill vs response, then IDLE proven by a prefetch grant (kill ignored in IDLE)
        vecs[12] = '{1, 40'h400,       0, 0, 40'h0,   1, 0, 0,   1, 0,  1, 40'h400,       0, 0, 0, 0, 40'h0,   2'd1};
        vecs[13] = '{0, 40'h0,         1, 0, 40'h0,   1, 1, 0,   0, 0,  0, 40'h0,         1, 0, 0, 0, 40'h0,   2'd1};
        vecs[14] = '{0, 40'h0,         1, 1, 40'h440, 1, 0, 0,   0, 1,  1, 40'h440,       0, 0, 0, 0, 40'h0,   2'd1};
        // TLB exception on prefetch (dropped), then on fetch (forwarded)
        vecs[15] = '{0, 40'h0,         0, 0, 40'h0,   1, 0, 1,   0, 0,  0, 40'h0,         0, 0, 0, 0, 40'h0,   2'd1};
        vecs[16] = '{1, 40'h500,       0, 0, 40'h0,   1, 0, 0,   1, 0,  1, 40'h500,       0, 0, 0, 0, 40'h0,   2'd2};
        vecs[17] = '{0, 40'h0,         0, 0, 40'h0,   0, 0, 1,   0, 0,  0, 40'h0,         0, 1, 1, 0, 40'h0,   2'd2};
        // response in IDLE is never forwarded
        vecs[18] = '{0, 40'h0,         0, 0, 40'h0,   0, 1, 0,   0, 0,  0, 40'h0,         0, 0, 0, 0, 40'h0,   2'd2};

        zero_inputs();
        rstn = 1'b0;
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            line              = line_base + 128'(i);
            fetch_req_valid   = vecs[i].fv;
            fetch_req_vaddr   = vecs[i].fa;
            fetch_kill        = vecs[i].fk;
            pf_req_valid      = vecs[i].pv;
            pf_req_vaddr      = vecs[i].pa;
            icache_req_ready  = vecs[i].rdy;
            icache_resp_valid = vecs[i].rv;
            icache_resp_data  = vecs[i].rv ? line : '0;
            tlb_xcpt          = vecs[i].tlb;
            exp_fd = vecs[i].e_frv ? icache_resp_data : '0;
            exp_pd = vecs[i].e_prv ? icache_resp_data : '0;
            #1;
            chk($sformatf("v%0d fetch_ready", i), 128'(fetch_req_ready), 128'(vecs[i].e_frdy));
            chk($sformatf("v%0d pf_ready", i),    128'(pf_req_ready), 128'(vecs[i].e_pfrdy));
            chk($sformatf("v%0d req_valid", i),   128'(icache_req_valid), 128'(vecs[i].e_iv));
            chk($sformatf("v%0d req_vaddr", i),   128'(icache_req_vaddr), 128'(vecs[i].e_ia));
            chk($sformatf("v%0d kill", i),        128'(icache_req_kill), 128'(vecs[i].e_kill));
            chk($sformatf("v%0d fetch_rv", i),    128'(fetch_resp_valid), 128'(vecs[i].e_frv));
            chk($sformatf("v%0d fetch_data", i),  fetch_resp_data, exp_fd);
            chk($sformatf("v%0d fetch_xcpt", i),  128'(fetch_resp_xcpt), 128'(vecs[i].e_fx));
            chk($sformatf("v%0d pf_rv", i),       128'(pf_resp_valid), 128'(vecs[i].e_prv));
            chk($sformatf("v%0d pf_vaddr", i),    128'(pf_resp_vaddr), 128'(vecs[i].e_pa));
            chk($sformatf("v%0d pf_data", i),     pf_resp_data, exp_pd);
            chk($sformatf("v%0d cnt", i),         128'(pf_drop_cnt), 128'(vecs[i].e_cnt));
            $display("vec %0d: fv=%0b pv=%0b rv=%0b tlb=%0b kill_in=%0b -> iv=%0b ia=%0h kill=%0b frv=%0b prv=%0b cnt=%0d",
                     i, vecs[i].fv, vecs[i].pv, vecs[i].rv, vecs[i].tlb, vecs[i].fk,
                     icache_req_valid, icache_req_vaddr, icache_req_kill,
                     fetch_resp_valid, pf_resp_valid, pf_drop_cnt);
        end

        // Saturation: fresh reset, five pre-emptions on a 2-bit counter.
        @(negedge clk);
        zero_inputs();
        rstn = 1'b0;
        #1;
        chk("sat reset cnt", 128'(pf_drop_cnt), 128'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pf_req_valid     = 1'b1;
            pf_req_vaddr     = 40'h600 + 40'(i * 64);
            icache_req_ready = 1'b1;
            #1;
            chk($sformatf("sat%0d pf_grant", i), 128'(pf_req_ready), 128'd1);
            @(negedge clk);
            pf_req_valid    = 1'b0;
            fetch_req_valid = 1'b1;
            fetch_req_vaddr = 40'h700;
            #1;
            chk($sformatf("sat%0d kill", i), 128'(icache_req_kill), 128'd1);
            @(negedge clk);
            zero_inputs();
            #1;
            chk($sformatf("sat%0d cnt", i), 128'(pf_drop_cnt), 128'((i + 1 > 3) ? 3 : i + 1));
            $display("preempt %0d: cnt=%0d", i, pf_drop_cnt);
        end

        // Reset while a prefetch is in flight with its response on the bus.
        @(negedge clk);
        pf_req_valid     = 1'b1;
        pf_req_vaddr     = 40'h880;
        icache_req_ready = 1'b1;
        #1;
        chk("midrst pf_grant", 128'(pf_req_ready), 128'd1);
        @(negedge clk);
        zero_inputs();
        icache_resp_valid = 1'b1;
        icache_resp_data  = line_base;
        #1;
        chk("midrst pf_rv_before", 128'(pf_resp_valid), 128'd1);
        chk("midrst pf_vaddr_before", 128'(pf_resp_vaddr), 128'h880);
        rstn = 1'b0;
        #1;
        chk_all_zero("midrst");
        $display("mid-access reset: pf_rv=%0b cnt=%0d", pf_resp_valid, pf_drop_cnt);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("stale fetch_rv", 128'(fetch_resp_valid), 128'd0);
        chk("stale pf_rv", 128'(pf_resp_valid), 128'd0);
        @(negedge clk);
        zero_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
